// File: rtl/nesapu_vgm_writer.sv
// VGM command stream parser driving NES APU register writes and pacing VGM waits.
// Optional: define NESAPU_VGM_WAIT7X_EN to accept 0x70-0x7F short-wait opcodes.
module nesapu_vgm_writer #(
  parameter int CLK_PER_SAMPLE = 41,
  parameter int WR_HOLD        = 2,
  parameter int WR_GAP         = 2
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       out_ready,
  output logic [4:0] out_reg,
  output logic [7:0] out_val,
  output logic       out_wr,
  output logic       out_done,
  output logic       out_error,
  output logic [2:0] dbg_state
);

  // Handshake: a byte moves on every rising edge where in_valid && out_ready;
  // out_ready never depends on in_valid, and the source may hold or drop
  // in_valid freely while out_ready is low.

  localparam int CW   = $clog2(CLK_PER_SAMPLE + 1);
  localparam int PMAX = (WR_HOLD > WR_GAP) ? WR_HOLD : WR_GAP;
  localparam int PW   = $clog2(PMAX + 1);

  typedef enum logic [2:0] {
    S_OP    = 3'd0,
    S_ARG1  = 3'd1,
    S_ARG2  = 3'd2,
    S_WR_HI = 3'd3,
    S_WR_LO = 3'd4,
    S_WAIT  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t        state, state_n;
  logic          op_wr, op_wr_n;
  logic [7:0]    arg1, arg1_n;
  logic [15:0]   samp, samp_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [PW-1:0] ph, ph_n;
  logic [4:0]    reg_n;
  logic [7:0]    val_n;
  logic          accept;

  assign out_ready = !in_rst && (state == S_OP || state == S_ARG1 || state == S_ARG2);
  assign out_wr    = !in_rst && (state == S_WR_HI);
  assign out_done  = (state == S_DONE);
  assign out_error = (state == S_ERR);
  assign dbg_state = state;
  assign accept    = in_valid && out_ready;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state   <= S_OP;
      op_wr   <= 1'b0;
      arg1    <= '0;
      samp    <= '0;
      cyc     <= '0;
      ph      <= '0;
      out_reg <= '0;
      out_val <= '0;
    end else begin
      state   <= state_n;
      op_wr   <= op_wr_n;
      arg1    <= arg1_n;
      samp    <= samp_n;
      cyc     <= cyc_n;
      ph      <= ph_n;
      out_reg <= reg_n;
      out_val <= val_n;
    end
  end

  always_comb begin
    state_n = state;
    op_wr_n = op_wr;
    arg1_n  = arg1;
    samp_n  = samp;
    cyc_n   = cyc;
    ph_n    = ph;
    reg_n   = out_reg;
    val_n   = out_val;
    case (state)
      S_OP: begin
        if (accept) begin
          case (in_data)
            8'hB4: begin op_wr_n = 1'b1; state_n = S_ARG1; end
            8'h61: begin op_wr_n = 1'b0; state_n = S_ARG1; end
            8'h62: begin samp_n = 16'd735; cyc_n = '0; state_n = S_WAIT; end
            8'h63: begin samp_n = 16'd882; cyc_n = '0; state_n = S_WAIT; end
            8'h66: state_n = S_DONE;
            default: begin
`ifdef NESAPU_VGM_WAIT7X_EN
              if (in_data[7:4] == 4'h7) begin
                samp_n  = 16'(in_data[3:0]) + 16'd1;
                cyc_n   = '0;
                state_n = S_WAIT;
              end else begin
                state_n = S_ERR;
              end
`else
              state_n = S_ERR;
`endif
            end
          endcase
        end
      end
      S_ARG1: begin
        if (accept) begin
          arg1_n  = in_data;
          state_n = S_ARG2;
        end
      end
      S_ARG2: begin
        if (accept) begin
          if (op_wr) begin
            // Addresses above 0x1F belong to a second APU or are invalid: drop.
            if (arg1[7:5] != 3'd0) begin
              state_n = S_OP;
            end else begin
              reg_n   = arg1[4:0];
              val_n   = in_data;
              ph_n    = '0;
              state_n = S_WR_HI;
            end
          end else if ({in_data, arg1} == 16'd0) begin
            state_n = S_OP;
          end else begin
            samp_n  = {in_data, arg1};
            cyc_n   = '0;
            state_n = S_WAIT;
          end
        end
      end
      S_WR_HI: begin
        if (ph == PW'(WR_HOLD - 1)) begin
          ph_n    = '0;
          state_n = S_WR_LO;
        end else begin
          ph_n = ph + 1'b1;
        end
      end
      S_WR_LO: begin
        if (ph == PW'(WR_GAP - 1)) begin
          ph_n    = '0;
          state_n = S_OP;
        end else begin
          ph_n = ph + 1'b1;
        end
      end
      S_WAIT: begin
        if (cyc == CW'(CLK_PER_SAMPLE - 1)) begin
          cyc_n  = '0;
          samp_n = samp - 16'd1;
          if (samp == 16'd1) state_n = S_OP;
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      default: state_n = state;
    endcase
  end

endmodule

// File: tb/tb_nesapu_vgm_writer.sv
// Bench for nesapu_vgm_writer: table vectors, randomized commands vs. a command-level model, corner sequences.
module tb_nesapu_vgm_writer;

  localparam int CPS  = 4;
  localparam int HOLD = 2;
  localparam int GAP  = 2;

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready, out_wr, out_done, out_error;
  logic [4:0] out_reg;
  logic [7:0] out_val;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;

  logic [4:0] m_reg = '0;
  logic [7:0] m_val = '0;

  typedef struct {
    logic [23:0] bytes;
    int          len;
    int          busy;
    int          pulses;
    logic [4:0]  rg;
    logic [7:0]  vl;
  } vec_t;

  vec_t tbl[16];
  int   n_tbl;

  nesapu_vgm_writer #(.CLK_PER_SAMPLE(CPS), .WR_HOLD(HOLD), .WR_GAP(GAP)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_data(in_data), .in_valid(in_valid),
    .out_ready(out_ready), .out_reg(out_reg), .out_val(out_val), .out_wr(out_wr),
    .out_done(out_done), .out_error(out_error), .dbg_state(dbg_state)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    @(posedge in_clk); #1;
    in_rst = 1'b0;
    #1;
    m_reg = '0;
    m_val = '0;
  endtask

  // Present one byte with in_valid high and return #1 after the edge that took it.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!out_ready && n < 5000) begin
      @(posedge in_clk); #1;
      n++;
    end
    if (n >= 5000) chk("send timeout", n, 0);
    @(posedge in_clk); #1;
    in_valid = 1'b0;
  endtask

  // Command-level reference: busy cycles and pulses derived from the opcode rules.
  function automatic void model(input logic [23:0] b, output int busy, output int pulses);
    logic [7:0] op, a1, a2;
    op = b[23:16]; a1 = b[15:8]; a2 = b[7:0];
    busy = 0; pulses = 0;
    if (op == 8'hB4) begin
      if (a1 < 8'd32) begin
        m_reg = a1[4:0]; m_val = a2;
        busy = HOLD + GAP; pulses = 1;
      end
    end else if (op == 8'h61) busy = (int'(a2) * 256 + int'(a1)) * CPS;
    else if (op == 8'h62) busy = 735 * CPS;
    else if (op == 8'h63) busy = 882 * CPS;
    else if (op[7:4] == 4'h7) busy = (int'(op[3:0]) + 1) * CPS;
  endfunction

  task automatic run_cmd(input logic [23:0] b, input int len, input int e_busy, input int e_pulses,
                         input logic [4:0] e_reg, input logic [7:0] e_val, input string tag);
    int busy = 0, pulses = 0, wcyc = 0, bad_val = 0;
    logic prev = 1'b0;
    for (int i = 0; i < len; i++) send_byte(b[23-8*i -: 8]);
    while (!out_ready && busy < e_busy + 50) begin
      if (out_wr) begin
        wcyc++;
        if (!prev) pulses++;
      end
      if (out_reg !== e_reg || out_val !== e_val) bad_val++;
      prev = out_wr;
      busy++;
      @(posedge in_clk); #1;
    end
    chk({tag, " busy"}, busy, e_busy);
    chk({tag, " pulses"}, pulses, e_pulses);
    chk({tag, " wr cycles"}, wcyc, e_pulses * HOLD);
    chk({tag, " reg/val unstable"}, bad_val, 0);
    chk({tag, " reg"}, int'(out_reg), int'(e_reg));
    chk({tag, " val"}, int'(out_val), int'(e_val));
    chk({tag, " done/err"}, int'({out_done, out_error}), 0);
  endtask

  task automatic check_terminal(input logic [7:0] op, input bit e_done, input bit e_err, input string tag);
    int leaks = 0;
    send_byte(op);
    chk({tag, " done at t+1"}, int'(out_done), int'(e_done));
    chk({tag, " err at t+1"}, int'(out_error), int'(e_err));
    repeat (30) begin
      if (out_ready || out_wr || out_done !== e_done || out_error !== e_err) leaks++;
      @(posedge in_clk); #1;
    end
    chk({tag, " sticky/ready low"}, leaks, 0);
  endtask

  initial begin
    int busy, pulses, k, cnt;
    logic [23:0] b;
    logic [7:0] a;

    n_tbl = 0;
    tbl[n_tbl++] = '{24'hB4035A, 3, 4,    1, 5'h03, 8'h5A};
    tbl[n_tbl++] = '{24'hB4150F, 3, 4,    1, 5'h15, 8'h0F};
    tbl[n_tbl++] = '{24'hB417C0, 3, 4,    1, 5'h17, 8'hC0};
    tbl[n_tbl++] = '{24'hB495FF, 3, 0,    0, 5'h17, 8'hC0};
    tbl[n_tbl++] = '{24'h610300, 3, 12,   0, 5'h17, 8'hC0};
    tbl[n_tbl++] = '{24'h610000, 3, 0,    0, 5'h17, 8'hC0};
    tbl[n_tbl++] = '{24'h620000, 1, 2940, 0, 5'h17, 8'hC0};
    tbl[n_tbl++] = '{24'hB41F81, 3, 4,    1, 5'h1F, 8'h81};
    tbl[n_tbl++] = '{24'hB42000, 3, 0,    0, 5'h1F, 8'h81};
    tbl[n_tbl++] = '{24'h630000, 1, 3528, 0, 5'h1F, 8'h81};
    tbl[n_tbl++] = '{24'h610501, 3, 1044, 0, 5'h1F, 8'h81};
`ifdef NESAPU_VGM_WAIT7X_EN
    tbl[n_tbl++] = '{24'h720000, 1, 12,   0, 5'h1F, 8'h81};
`endif

    repeat (2) @(posedge in_clk);
    #1;
    in_rst = 1'b0;
    #1;
    chk("reset ready", int'(out_ready), 1);
    chk("reset wr", int'(out_wr), 0);
    chk("reset reg", int'(out_reg), 0);
    chk("reset val", int'(out_val), 0);
    chk("reset done/err", int'({out_done, out_error}), 0);
    chk("reset state", int'(dbg_state), 0);

    for (int i = 0; i < n_tbl; i++)
      run_cmd(tbl[i].bytes, tbl[i].len, tbl[i].busy, tbl[i].pulses, tbl[i].rg, tbl[i].vl,
              $sformatf("tbl%0d", i));
    m_reg = tbl[n_tbl-1].rg;
    m_val = tbl[n_tbl-1].vl;

    for (int r = 0; r < 30; r++) begin
      k = $urandom_range(0, 9);
      if (k < 5 || k == 8) begin
        a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
        b = {8'hB4, a, 8'($urandom)};
`ifdef NESAPU_VGM_WAIT7X_EN
        if (k == 8) b = {4'h7, 4'($urandom_range(0, 15)), 16'h0000};
`endif
      end else if (k < 8) begin
        cnt = $urandom_range(0, 20);
        b = {8'h61, 8'(cnt), 8'h00};
      end else begin
        b = ($urandom_range(0, 1) == 0) ? 24'h620000 : 24'h630000;
      end
      model(b, busy, pulses);
      run_cmd(b, (b[23:16] == 8'hB4 || b[23:16] == 8'h61) ? 3 : 1, busy, pulses, m_reg, m_val,
              $sformatf("rnd%0d", r));
    end

    // Reset during a write pulse drops out_wr in the same cycle.
    send_byte(8'hB4); send_byte(8'h01); send_byte(8'h11);
    chk("wr before reset", int'(out_wr), 1);
    in_rst = 1'b1;
    #1;
    chk("wr during reset", int'(out_wr), 0);
    chk("ready during reset", int'(out_ready), 0);
    @(posedge in_clk); #1;
    in_rst = 1'b0;
    #1;
    chk("post-reset reg", int'(out_reg), 0);
    chk("post-reset val", int'(out_val), 0);
    chk("post-reset state", int'(dbg_state), 0);
    m_reg = '0; m_val = '0;

    check_terminal(8'h66, 1'b1, 1'b0, "end 66");
    do_reset();
    check_terminal(8'h4F, 1'b0, 1'b1, "bad 4F");
    do_reset();
`ifndef NESAPU_VGM_WAIT7X_EN
    check_terminal(8'h72, 1'b0, 1'b1, "short 72 off");
    do_reset();
`endif

    // Reset in the middle of a long wait.
    send_byte(8'h61); send_byte(8'hFF); send_byte(8'hFF);
    repeat (10) begin @(posedge in_clk); #1; end
    chk("long wait busy", int'(out_ready), 0);
    in_rst = 1'b1;
    @(posedge in_clk); #1;
    in_rst = 1'b0;
    #1;
    chk("abort state", int'(dbg_state), 0);
    chk("abort ready", int'(out_ready), 1);
    chk("abort reg/val", int'({out_reg, out_val}), 0);
    chk("abort wr/done/err", int'({out_wr, out_done, out_error}), 0);
    run_cmd(24'hB4003F, 3, 4, 1, 5'h00, 8'h3F, "after abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nesapu_vgm_writer.md
# nesapu_vgm_writer

Parses a VGM command byte stream and drives register writes into the NES APU register port (register index, value, write strobe). Sits between the VGM byte source (ROM/FIFO reader) and the APU. It also times VGM wait commands in 44.1 kHz sample units derived from the APU clock, so playback pacing is handled entirely in this block.

## Interface

Parameters:
- `CLK_PER_SAMPLE`, default 41: APU clocks per VGM sample (1.79 MHz / 44100). Must be at least 1.
- `WR_HOLD`, default 2: cycles `out_wr` stays high per write. Must be at least 1.
- `WR_GAP`, default 2: cycles `out_wr` stays low after each write before the next byte is accepted. Must be at least 1.

Ports:
- `in_clk` in 1: the single clock.
- `in_rst` in 1: reset, synchronous, active-high.
- `in_data` in 8: VGM stream byte.
- `in_valid` in 1: `in_data` is valid.
- `out_ready` out 1: block accepts `in_data` this cycle.
- `out_reg` out 5: APU register index.
- `out_val` out 8: APU register value.
- `out_wr` out 1: write strobe. The APU latches on its rising edge.
- `out_done` out 1: end-of-stream (0x66) reached. Sticky.
- `out_error` out 1: unsupported opcode seen. Sticky.

## Operation

- A byte transfers on any cycle with `in_valid && out_ready`.
- `out_ready` is 1 only in states OP, ARG1 and ARG2. It is forced to 0 while `in_rst` is high.
- States: OP, ARG1, ARG2, WR_HI, WR_LO, WAIT, DONE, ERR.
- OP decodes the opcode and latches it:
  - 0xB4: go to ARG1 (addr), then ARG2 (data), then WR_HI.
  - 0x61: go to ARG1 (count lo), then ARG2 (count hi), then WAIT. The 16-bit count is little-endian.
  - 0x62: WAIT with count 735.
  - 0x63: WAIT with count 882.
  - 0x70–0x7F: WAIT with count n+1 (only when the macro is set; see Configuration).
  - 0x66: go to DONE.
  - Any other opcode: go to ERR.
- 0xB4 address handling:
  - If `addr[7:5] != 0` (second chip or out of range), the write is dropped and the state returns to OP.
  - Otherwise `out_reg <= addr[4:0]` and `out_val <= data` are latched on acceptance of the data byte.
- WR_HI: `out_wr` = 1 for `WR_HOLD` cycles, then WR_LO.
- WR_LO: `out_wr` = 0 for `WR_GAP` cycles, then OP.
- `out_reg` and `out_val` hold their values until the next non-dropped write.
- WAIT:
  - A 16-bit sample counter and a cycle counter of width `$clog2(CLK_PER_SAMPLE+1)` run.
  - Each time the cycle counter wraps, one sample is decremented.
  - When the sample count reaches 0, the state returns to OP.
  - A count of 0 (0x61 00 00) returns directly to OP and spends no cycles in WAIT.
- DONE and ERR are terminal until reset. In both, `out_ready` = 0 and `out_wr` = 0.
- Reset values: state OP, `out_reg` 0, `out_val` 0, `out_wr` 0, `out_done` 0, `out_error` 0, all counters 0.
- Reset mid-operation aborts immediately. A partially received command is discarded, a wait is cancelled, and `out_wr` drops in the same cycle the reset is sampled.

## Timing

- Each cycle below is counted from t, the cycle on which the final byte of a command is accepted.
- Write:
  - `out_wr` is high on cycles t+1 … t+WR_HOLD.
  - `out_reg` and `out_val` are valid from t+1 and stable through t+WR_HOLD+WR_GAP.
  - `out_ready` returns to 1 at t+1+WR_HOLD+WR_GAP.
- Dropped write: `out_ready` is 1 at t+1.
- Wait of N samples, N ≥ 1: `out_ready` is 0 on cycles t+1 … t+N·CLK_PER_SAMPLE and returns to 1 at t+1+N·CLK_PER_SAMPLE.
- Wait of 0 samples: `out_ready` is 1 at t+1.
- `out_done` and `out_error` rise at t+1 after the 0x66 or bad opcode is accepted.
- Consecutive writes always keep `out_wr` low for at least `WR_GAP` ≥ 1 cycles, so every write produces a distinct rising edge.
- Multi-byte commands with `in_valid` gaps wait indefinitely in ARG1/ARG2. There is no timeout.

## Configuration

- `NESAPU_VGM_WAIT7X_EN`:
  - Defined: opcodes 0x70–0x7F are short waits of (opcode[3:0]+1) samples.
  - Undefined: 0x70–0x7F are unsupported and go to ERR with `out_error` = 1.

## Test plan

Bench parameters: `CLK_PER_SAMPLE`=4, `WR_HOLD`=2, `WR_GAP`=2, `in_valid` held high.

- **Single write.** Stream B4 03 5A → `out_wr` high for exactly 2 cycles with `out_reg`=0x03 and `out_val`=0x5A; `out_ready` is low for 4 cycles after the last byte.
- **Back-to-back and dropped writes.**
  - B4 15 0F B4 17 C0 → two separate rising edges of `out_wr`, with values (0x15, 0x0F) then (0x17, 0xC0).
  - B4 95 FF → no `out_wr` pulse, and `out_reg`/`out_val` are unchanged.
- **Waits.**
  - 61 03 00 → `out_ready` is low for exactly 12 cycles.
  - 61 00 00 → `out_ready` is high on the very next cycle.
  - 62 → `out_ready` is low for 2940 cycles.
- **Short wait.**
  - Macro defined: 72 → `out_ready` is low for 12 cycles.
  - Macro undefined: 72 → `out_error`=1 at the next cycle and `out_ready` stays 0.
- **Termination.**
  - 66 → `out_done`=1 and `out_ready`=0 forever.
  - 4F → `out_error`=1 and it stays sticky.
- **Reset mid-operation.**
  - Assert `in_rst` during a 61 FF FF wait → on the next cycle all outputs are at reset values and the block is in OP.
  - Then stream B4 00 3F → the write is seen normally.
